// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants, instruction formats and FIFO state type
// used by the instruction encoder and its packing sub-module.
package riscv_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } fifo_state_e;

  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    fmt_e f;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_JAL:                   f = FMT_J;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: builds the 32-bit instruction word from decoded fields
// and flags immediates that do not fit the selected format.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic i_fits;
  logic b_fits;
  logic j_fits;
  fmt_e fmt;

  // An immediate fits when every bit above the field's sign bit copies it.
  assign i_fits = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign fmt    = fmt_of(opcode);

  always_comb begin
    inst = NOP;
    err  = 1'b1;
    case (fmt)
      FMT_I: if (i_fits) begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = 1'b0;
      end
      FMT_S: if (i_fits) begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = 1'b0;
      end
      FMT_B: if (b_fits) begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = 1'b0;
      end
      FMT_J: if (j_fits) begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = 1'b0;
      end
      default: begin
        inst = NOP;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs requests at acceptance and queues the results in
// a two-entry FIFO, with a saturating count of rejected requests.
module inst_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_count,
  output fifo_state_e dbg_state
);

  // Handshake: a side transfers on a rising edge where its valid and ready are
  // both high; the producer holds its payload steady until that edge.
  fifo_state_e state;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic [31:0] tail_inst;
  logic        tail_err;
  logic        push;
  logic        pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign dbg_state = state;

  inst_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .inst   (enc_inst),
    .err    (enc_err)
  );

  // The head entry lives directly in out_inst/out_err; tail_* is the second slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_inst  <= NOP;
      out_err   <= 1'b0;
      tail_inst <= NOP;
      tail_err  <= 1'b0;
      err_count <= 16'd0;
    end else begin
      if (push && enc_err && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      case (state)
        ST_EMPTY: begin
          if (push) begin
            out_inst  <= enc_inst;
            out_err   <= enc_err;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b11: begin
              out_inst <= enc_inst;
              out_err  <= enc_err;
            end
            2'b10: begin
              tail_inst <= enc_inst;
              tail_err  <= enc_err;
              in_ready  <= 1'b0;
              state     <= ST_TWO;
            end
            2'b01: begin
              out_valid <= 1'b0;
              state     <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (pop) begin
            out_inst <= tail_inst;
            out_err  <= tail_err;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors, backpressure, reset flush, random
// traffic against a range-based reference model, and counter saturation.
module tb_inst_encoder;

  localparam logic [6:0] T_LOAD = 7'b0000011;
  localparam logic [6:0] T_IMM  = 7'b0010011;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_S    = 7'b0100011;
  localparam logic [6:0] T_B    = 7'b1100011;
  localparam logic [6:0] T_J    = 7'b1101111;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_count;
  riscv_pkg::fifo_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_err_cnt = 0;
  logic [64:0] exp_q[$];   // {err, imm, inst}
  logic        held = 1'b0;
  logic [32:0] held_val;
  logic        rand_done;

  inst_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [31:0] imm);
    longint v;
    bit ok;
    logic [31:0] w;
    v  = $signed(imm);
    ok = 1'b0;
    w  = 32'h00000013;
    case (op)
      T_LOAD, T_IMM, T_JALR: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = {imm[11:0], rs1, f3, rd, op};
      end
      T_S: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      T_B: begin
        ok = (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      T_J: begin
        ok = (v >= -1048576) && (v <= 1048575) && (imm[0] == 1'b0);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h00000013};
    return {1'b0, w};
  endfunction

  function automatic longint decode_imm(input logic [31:0] inst);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    longint r;
    r = 0;
    case (inst[6:0])
      T_LOAD, T_IMM, T_JALR: begin i12 = inst[31:20]; r = i12; end
      T_S: begin i12 = {inst[31:25], inst[11:7]}; r = i12; end
      T_B: begin b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; r = b13; end
      T_J: begin j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; r = j21; end
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    logic [32:0] e;
    int n;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    e = ref_encode(op, rd, rs1, rs2, f3, imm);
    exp_q.push_back({e[32], imm, e[31:0]});
    if (e[32] && exp_err_cnt < 65535) exp_err_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand_fields(input logic [6:0] op, input logic [31:0] imm);
    send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), imm);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%0b expected 0/0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (held) begin
        check("stable_inst", out_inst, held_val[31:0]);
        check("stable_err", out_err, held_val[32]);
      end
      if (out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got 0x%0h expected none", out_inst);
        end else begin
          e = exp_q.pop_front();
          check("out_inst", out_inst, e[31:0]);
          check("out_err", out_err, e[64]);
          if (!e[64]) check("round_trip", decode_imm(out_inst), longint'($signed(e[63:32])));
        end
      end else begin
        held     = 1'b1;
        held_val = {out_err, out_inst};
      end
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] ops[6];

  initial begin
    ops[0] = T_LOAD; ops[1] = T_IMM; ops[2] = T_JALR;
    ops[3] = T_S;    ops[4] = T_B;   ops[5] = T_J;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rand_done = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_inst", out_inst, 32'h00000013);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed vectors, each observed one cycle after acceptance
    send(T_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    check("addi_valid", out_valid, 1);
    check("addi_inst", out_inst, 32'hFFF00093);
    check("addi_err", out_err, 0);
    send(T_S, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8);
    check("sw_inst", out_inst, 32'h0021A423);
    send(T_J, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    check("jal_inst", out_inst, 32'h001000EF);
    send(T_B, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    check("b_odd_inst", out_inst, 32'h00000013);
    check("b_odd_err", out_err, 1);
    check("b_odd_cnt", err_count, 1);
    send(T_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 32'h800);
    check("i_range_err", out_err, 1);
    check("i_range_cnt", err_count, 2);
    wait_drain();

    // backpressure: third request must stall until a slot frees
    out_ready = 1'b0;
    send(T_LOAD, 5'd5, 5'd6, 5'd0, 3'd2, 32'h7FF);
    send(T_B, 5'd0, 5'd7, 5'd8, 3'd1, 32'hFFFFF000);
    in_valid = 1'b1; in_opcode = T_JALR; in_rd = 5'd9; in_rs1 = 5'd10; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'hFFFFF800;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", in_ready, 1);
    begin
      logic [32:0] e;
      e = ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
      exp_q.push_back({e[32], in_imm, e[31:0]});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // reset while two entries are buffered
    out_ready = 1'b0;
    send(T_B, 5'd0, 5'd1, 5'd1, 3'd0, 32'd5);
    send(T_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 32'd100);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_out_inst", out_inst, 32'h00000013);
    exp_q.delete();
    exp_err_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(T_IMM, 5'd4, 5'd5, 5'd0, 3'd7, 32'd42);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_inst", out_inst, {12'd42, 5'd5, 3'd7, 5'd4, T_IMM});
    wait_drain();

    // random traffic with random output backpressure
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          int kind;
          int fi;
          logic [31:0] imm;
          kind = $urandom_range(0, 9);
          fi   = $urandom_range(0, 5);
          case (ops[fi])
            T_B:     imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            T_J:     imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            default: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
          endcase
          if (kind == 8) imm = $urandom;
          if (kind == 9) send_rand_fields(7'($urandom_range(0, 127)), imm);
          else           send_rand_fields(ops[fi], imm);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_err_count", err_count, 64'(exp_err_cnt));

    // saturation of the error counter
    for (int k = 0; k < 65540; k++) send_rand_fields(T_B, 32'd3);
    wait_drain();
    check("sat_err_count", err_count, 16'hFFFF);
    check("sat_model_count", err_count, 64'(exp_err_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. Ports are listed below as name  direction  width  meaning.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request fields are valid.
REQ-005 in_ready  output  1  encoder can accept a request; registered.
REQ-006 in_opcode  input  7  opcode: 0000011 load, 0010011 I-arith, 1100111 JALR, 0100011 S, 1100011 B, 1101111 JAL.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_imm  input  32  signed immediate value, byte offset for B/J.
REQ-010 out_valid  output  1  out_inst/out_err valid.
REQ-011 out_ready  input  1  consumer accepts output.
REQ-012 out_inst  output  32  encoded instruction word.
REQ-013 out_err  output  1  request not encodable; out_inst is NOP.
REQ-014 err_count  output  16  saturating count of errored requests accepted.

Function
REQ-015 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-016 The encoder SHALL buffer 2 entries in FIFO order, with states EMPTY, ONE, TWO.
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
REQ-017 State transitions SHALL be:
  - push only: EMPTY->ONE->TWO.
  - pop only: TWO->ONE->EMPTY.
  - push+pop in ONE: stay ONE, new entry queued behind head.
  - push+pop in TWO: impossible, since in_ready=0.
REQ-018 Latency SHALL be 1 cycle: a request accepted into EMPTY appears on out_inst the next cycle.
REQ-019 Full throughput (1 request/cycle) SHALL be sustained while out_ready=1.
REQ-020 I formats (load, I-arith, JALR) SHALL encode as {imm[11:0], rs1, funct3, rd, opcode}.
  - Legal iff imm[31:11] are all equal.
REQ-021 S format SHALL encode as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Legal iff imm[31:11] are all equal.
REQ-022 B format SHALL encode as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Legal iff imm[31:12] are all equal and imm[0]=0.
REQ-023 J format SHALL encode as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; funct3/rs fields are ignored.
  - Legal iff imm[31:20] are all equal and imm[0]=0.
REQ-024 Illegal immediates and unsupported opcodes SHALL produce out_inst=32'h00000013 and out_err=1.
REQ-025 Encoding and range check SHALL be evaluated at acceptance, and the result SHALL be stored in the buffer.
REQ-026 Round-trip: for every legal request, sign-extending the immediate decoded from out_inst by format SHALL equal in_imm.
REQ-027 err_count SHALL increment on acceptance of an errored request and saturate at 16'hFFFF.
REQ-028 out_inst and out_err SHALL stay stable while out_valid && !out_ready.
REQ-029 Fields ignored by a format SHALL NOT affect out_inst.

Reset
REQ-030 While reset=1, and asynchronously on its assertion, the block SHALL force:
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_inst=32'h00000013, out_err=0, err_count=0.
REQ-031 Reset SHALL discard buffered entries mid-operation; no transfer is signalled in the reset cycle.

Structure
REQ-032 Opcode constants, a format enum (FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD) and the NOP constant SHALL live in the shared package riscv_pkg.
REQ-033 Encoding and range check SHALL be a combinational sub-module inst_pack: opcode/fields/imm in, inst/err out.
  - inst_encoder holds the FIFO, state machine and counter.

Verification
REQ-034 I-arith, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, one cycle after acceptance.
REQ-035 S, rs1=3, rs2=2, funct3=010, imm=8 -> out_inst=0x0021A423.
REQ-036 JAL, rd=1, imm=0x800 -> 0x001000EF.
  - B, imm=3 -> 0x00000013, out_err=1, err_count=1.
  - I, imm=0x800 -> out_err=1.
REQ-037 Backpressure: out_ready=0, offer 3 requests -> only 2 accepted, in_ready=0; then out_ready=1 -> outputs in order, in_ready=1 the next cycle.
REQ-038 Two entries buffered, reset pulsed -> out_valid=0, in_ready=1, err_count=0 immediately; next request has latency 1.
REQ-039 Random legal requests checked by the imm_Gen round-trip, plus forced err_count saturation at 0xFFFF.
